// File: rtl/aux_uart_boot_rx.sv
// rtl/aux_uart_boot_rx.sv - aux UART 8N1 boot image receiver packing bytes into 32-bit memory writes
`timescale 1ns/1ps
module aux_uart_boot_rx #(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int ADDR_WIDTH    = 14,
    parameter int IDLE_TIMEOUT  = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  boot_valid,
    output logic [ADDR_WIDTH-1:0] boot_addr,
    output logic [31:0]           boot_wdata,
    output logic                  boot_active,
    output logic                  frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int IDLE_W       = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // Loading this value makes the first tick land half a bit after the falling edge.
    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_s;
    logic [CNT_W-1:0]        bit_cnt;
    logic [2:0]              bit_idx;
    logic [7:0]              shift_reg;
    logic [1:0]              byte_idx;
    logic [23:0]             word_buf;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [IDLE_W-1:0]       idle_cnt;
    logic                    bit_tick;

    assign bit_tick = (bit_cnt == BIT_LAST);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM, byte packing, address counter and session idle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            addr        <= '0;
            idle_cnt    <= '0;
            boot_valid  <= 1'b0;
            boot_addr   <= '0;
            boot_wdata  <= '0;
            boot_active <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            boot_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (state != IDLE) begin
                bit_cnt <= bit_tick ? '0 : bit_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    // A start edge takes priority over a timeout in the same cycle.
                    if (!rx_s) begin
                        state    <= START;
                        bit_cnt  <= HALF_LOAD;
                        idle_cnt <= '0;
                    end else if (boot_active) begin
                        if (idle_cnt == IDLE_LAST) begin
                            boot_active <= 1'b0;
                            byte_idx    <= '0;
                            addr        <= '0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                START: begin
                    if (bit_tick) begin
                        if (!rx_s) begin
                            state       <= DATA;
                            bit_idx     <= '0;
                            boot_active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (rx_s) begin
                            state    <= IDLE;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                boot_wdata <= {shift_reg, word_buf};
                                boot_addr  <= addr;
                                boot_valid <= 1'b1;
                                addr       <= addr + ADDR_WIDTH'(1);
                            end else begin
                                word_buf[{byte_idx, 3'b000} +: 8] <= shift_reg;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aux_uart_boot_rx.sv
// tb/tb_aux_uart_boot_rx.sv - scoreboard testbench for aux_uart_boot_rx
`timescale 1ns/1ps
module tb_aux_uart_boot_rx;

    localparam int BAUD    = 115_200;
    localparam int CPB     = 64;
    localparam int CLK_F   = CPB * BAUD;
    localparam int AW      = 2;
    localparam int IDLE_TO = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          boot_valid;
    logic [AW-1:0] boot_addr;
    logic [31:0]   boot_wdata;
    logic          boot_active;
    logic          frame_error;

    aux_uart_boot_rx #(
        .CLK_FREQUENCY(CLK_F),
        .BAUD_RATE    (BAUD),
        .ADDR_WIDTH   (AW),
        .IDLE_TIMEOUT (IDLE_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .boot_valid (boot_valid),
        .boot_addr  (boot_addr),
        .boot_wdata (boot_wdata),
        .boot_active(boot_active),
        .frame_error(frame_error)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            fe_count = 0;
    int            valid_count = 0;
    logic [AW-1:0] m_addr;
    int            m_idx;
    logic [31:0]   m_word;

    // Write monitor: every boot_valid strobe is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (frame_error === 1'b1) fe_count++;
            if (boot_valid === 1'b1) begin
                valid_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write got addr=%0d data=%h, required no write", boot_addr, boot_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (boot_addr !== mon_e.addr || boot_wdata !== mon_e.data) begin
                        n_err++;
                        $display("FAIL write got addr=%0d data=%h, required addr=%0d data=%h",
                                 boot_addr, boot_wdata, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_idx  = 0;
        m_addr = '0;
        m_word = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(posedge clk);
        repeat (4) @(posedge clk);
    endtask

    // The model is updated before the frame goes out: the write strobe fires inside the stop bit.
    task automatic send_good(input logic [7:0] b);
        m_word[m_idx*8 +: 8] = b;
        if (m_idx == 3) begin
            exp_q.push_back('{addr: m_addr, data: m_word});
            m_addr = m_addr + 1'b1;
            m_idx  = 0;
        end else begin
            m_idx++;
        end
        send_frame(b, 1'b1);
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_active(input string name, input logic required);
        #1;
        n_cmp++;
        if (boot_active !== required) begin
            n_err++;
            $display("FAIL %s_active got %b, required %b", name, boot_active, required);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({boot_valid, boot_addr, boot_wdata, boot_active, frame_error} !== '0) begin
            n_err++;
            $display("FAIL %s got valid=%b addr=%0d data=%h active=%b ferr=%b, required all 0",
                     name, boot_valid, boot_addr, boot_wdata, boot_active, frame_error);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_single_word();
        do_reset();
        send_good(8'h13);
        send_good(8'h05);
        send_good(8'h00);
        send_good(8'h00);
        check_drained("single_word");
        check_active("single_word", 1'b1);
    endtask

    task automatic test_two_words();
        do_reset();
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        check_drained("two_words");
    endtask

    task automatic test_glitch();
        int fe0;
        int v0;
        do_reset();
        fe0 = fe_count;
        v0  = valid_count;
        rx = 1'b0;
        #400;
        rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        check_active("glitch", 1'b0);
        n_cmp++;
        if (fe_count != fe0 || valid_count != v0) begin
            n_err++;
            $display("FAIL glitch_events got ferr=%0d writes=%0d, required 0 and 0", fe_count - fe0, valid_count - v0);
        end
    endtask

    task automatic test_frame_error();
        int fe0;
        do_reset();
        fe0 = fe_count;
        send_frame(8'hAA, 1'b0);
        n_cmp++;
        if (fe_count != fe0 + 1) begin
            n_err++;
            $display("FAIL frame_error_pulse got %0d pulses, required 1", fe_count - fe0);
        end
        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);
        check_drained("frame_error");
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  fell;
        do_reset();
        send_good(8'hDE);
        send_good(8'hAD);
        check_active("timeout_before", 1'b1);
        fell = 1'b0;
        cyc  = 0;
        for (int i = 0; i < IDLE_TO + 200 && !fell; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (boot_active === 1'b0) fell = 1'b1;
        end
        n_cmp++;
        if (!fell || cyc < IDLE_TO - CPB || cyc > IDLE_TO + 10) begin
            n_err++;
            $display("FAIL timeout_fall got fell=%b after %0d cycles, required fall within [%0d,%0d]",
                     fell, cyc, IDLE_TO - CPB, IDLE_TO + 10);
        end
        model_clear();
        send_good(8'hA1);
        send_good(8'hB2);
        send_good(8'hC3);
        send_good(8'hD4);
        check_drained("timeout");
    endtask

    task automatic test_addr_wrap();
        do_reset();
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) send_good(8'($urandom_range(0, 255)));
        end
        check_drained("addr_wrap");
    endtask

    task automatic test_reset_mid();
        send_good(8'h5A);
        send_good(8'hC3);
        check_active("mid_before", 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_byte");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
        send_good(8'h01);
        send_good(8'h23);
        send_good(8'h45);
        send_good(8'h67);
        check_drained("reset_mid");
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        model_clear();
        test_reset();
        test_single_word();
        test_two_words();
        test_glitch();
        test_frame_error();
        test_timeout();
        test_addr_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
